// File: rtl/hazard_pkg.sv
// Purpose: shared constants for the pipeline hazard controller (FSM states, forward selects).
// Latency: n/a (package only).
// Backpressure: n/a; fw_sel() is the operand-forwarding priority rule, MEM stage before WB.
package hazard_pkg;

  // Memory wait FSM state encoding
  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // EXE operand mux selects
  localparam logic [1:0] FW_REG = 2'b00;
  localparam logic [1:0] FW_MEM = 2'b01;
  localparam logic [1:0] FW_WB  = 2'b10;

  // The MEM-stage result is younger than the WB result, so it wins when both match.
  function automatic logic [1:0] fw_sel(input logic [3:0] src_fu,
                                        input logic [3:0] mem_dest,
                                        input logic       mem_wb_en,
                                        input logic [3:0] wb_dest,
                                        input logic       wb_en);
    if (mem_wb_en && (src_fu == mem_dest))
      return FW_MEM;
    else if (wb_en && (src_fu == wb_dest))
      return FW_WB;
    else
      return FW_REG;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose: bundles the ID/EXE/MEM/WB status inputs and the hazard/flush/freeze/forward outputs.
// Latency: n/a (wiring only).
// Backpressure: freeze is the only hold signal; the bundle carries no valid/ready handshake.
// Modports: slave = the controller (reads stage status, drives controls);
//           master = the pipeline side (drives stage status, reads controls).
interface pipeline_hazard_ctrl_if;
  logic [3:0] src1;
  logic [3:0] src2;
  logic       two_src;
  logic [3:0] exe_dest;
  logic       exe_wb_en;
  logic       exe_mem_r_en;
  logic [3:0] mem_dest;
  logic       mem_wb_en;
  logic       mem_r_en;
  logic       mem_w_en;
  logic [3:0] src1_fu;
  logic [3:0] src2_fu;
  logic [3:0] wb_dest;
  logic       wb_en;
  logic       branch_taken;
  logic       hazard;
  logic       flush;
  logic       freeze;
  logic [1:0] sel_src1;
  logic [1:0] sel_src2;

  modport slave (
    input  src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, mem_r_en, mem_w_en,
           src1_fu, src2_fu, wb_dest, wb_en, branch_taken,
    output hazard, flush, freeze, sel_src1, sel_src2
  );

  modport master (
    output src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, mem_r_en, mem_w_en,
           src1_fu, src2_fu, wb_dest, wb_en, branch_taken,
    input  hazard, flush, freeze, sel_src1, sel_src2
  );
endinterface

// File: rtl/mem_wait_fsm.sv
// Purpose: wait-state FSM that freezes the pipeline while a data-memory access occupies MEM.
// Latency: freeze rises combinationally with mem_req and stays high MEM_LATENCY-1 cycles.
// Backpressure: freeze holds every stage register; mem_req is ignored in DONE (same access leaving).
// Ports: clk, rst (async active-low, also forces freeze low), mem_req in, freeze out.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_LATENCY = 6,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic freeze
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LATENCY >= 3) ? (MEM_LATENCY - 2) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             freeze_raw;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    freeze_raw = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && (MEM_LATENCY >= 2)) begin
          freeze_raw = 1'b1;
          if (MEM_LATENCY >= 3) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      WAIT: begin
        freeze_raw = 1'b1;
        cnt_nxt    = cnt - CNT_ONE;
        if (cnt == CNT_ONE)
          state_nxt = DONE;
      end
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Gating with rst drops freeze in the very cycle reset asserts, even mid-access.
  assign freeze = freeze_raw & rst;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: pipeline sequencer: RAW hazard stall, branch flush, memory freeze, forward selects.
// Latency: all controls combinational from current stage status; only the freeze FSM holds state.
// Backpressure: freeze holds all stages and dominates hazard; flush masks hazard and is held off while frozen.
// Ports: clk, rst (async active-low, forces all outputs low), bus (pipeline_hazard_ctrl_if.slave).
// Build option: FORWARDING_EN -> load-use-only hazard plus sel_src1/sel_src2; otherwise full RAW stall, selects tied 00.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_LATENCY = 6,
  parameter int CNT_W       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_hazard_ctrl_if.slave       bus
);

  logic       mem_req;
  logic       freeze_int;
  logic       flush_int;
  logic       raw;
  logic [1:0] sel1_int;
  logic [1:0] sel2_int;

  assign mem_req = bus.mem_r_en | bus.mem_w_en;

  mem_wait_fsm #(
    .MEM_LATENCY (MEM_LATENCY),
    .CNT_W       (CNT_W)
  ) u_mem_wait_fsm (
    .clk     (clk),
    .rst     (rst),
    .mem_req (mem_req),
    .freeze  (freeze_int)
  );

  // A branch seen while frozen stays pending in EXE and flushes on the first unfrozen cycle.
  assign flush_int = bus.branch_taken & ~freeze_int;

`ifdef FORWARDING_EN
  logic load_in_exe;
  assign load_in_exe = bus.exe_mem_r_en & bus.exe_wb_en;
  // Everything except load-use is covered by the forwarding muxes.
  assign raw = load_in_exe & ((bus.src1 == bus.exe_dest) |
                              (bus.two_src & (bus.src2 == bus.exe_dest)));
  assign sel1_int = fw_sel(bus.src1_fu, bus.mem_dest, bus.mem_wb_en, bus.wb_dest, bus.wb_en);
  assign sel2_int = fw_sel(bus.src2_fu, bus.mem_dest, bus.mem_wb_en, bus.wb_dest, bus.wb_en);
`else
  logic raw1;
  logic raw2;
  logic unused_fwd;
  assign raw1 = (bus.exe_wb_en & (bus.src1 == bus.exe_dest)) |
                (bus.mem_wb_en & (bus.src1 == bus.mem_dest));
  assign raw2 = bus.two_src & ((bus.exe_wb_en & (bus.src2 == bus.exe_dest)) |
                               (bus.mem_wb_en & (bus.src2 == bus.mem_dest)));
  assign raw      = raw1 | raw2;
  assign sel1_int = FW_REG;
  assign sel2_int = FW_REG;
  assign unused_fwd = ^{bus.exe_mem_r_en, bus.src1_fu, bus.src2_fu, bus.wb_dest, bus.wb_en};
`endif

  assign bus.hazard   = rst & raw & ~flush_int;
  assign bus.flush    = rst & flush_int;
  assign bus.freeze   = freeze_int;
  assign bus.sel_src1 = rst ? sel1_int : FW_REG;
  assign bus.sel_src2 = rst ? sel2_int : FW_REG;

endmodule
